// File: rtl/dmem_responder.sv
// Data-side responder: word RAM plus TXDATA/STATUS/CYCLES MMIO for the memory stage.
// Define DMEM_OOB_TRAP_EN to trap out-of-range RAM and unmapped accesses into a sticky err.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q;
   logic [31:0]   cycles_q, cycles_d;

   logic          low_page, ram_sel, tx_sel, st_sel, cy_sel;
   logic          st_wr, cy_wr;
   logic [AW-1:0] ram_idx;
   logic          fifo_empty, fifo_full, push, pop, push_ok;
   logic [31:0]   status;
   logic          unused_addr;

   assign low_page = (Addr[31:12] == 20'd0);
   assign tx_sel   = (Addr[31:2] == 30'h0000_0400);
   assign st_sel   = (Addr[31:2] == 30'h0000_0401);
   assign cy_sel   = (Addr[31:2] == 30'h0000_0402);
   assign ram_idx  = Addr[AW+1:2];
   assign st_wr    = MemWrite && st_sel;
   assign cy_wr    = MemWrite && cy_sel;
   assign unused_addr = ^Addr[11:0];

`ifdef DMEM_OOB_TRAP_EN
   logic oob;
   logic err_q;

   assign ram_sel = low_page && ({22'd0, Addr[11:2]} < 32'(DEPTH_WORDS));
   assign oob     = !(ram_sel || tx_sel || st_sel || cy_sel);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (oob) begin
         err_q <= 1'b1;
      end else if (st_wr && WriteData[3]) begin
         err_q <= 1'b0;
      end
   end

   assign err = err_q;
`else
   // Without the trap the RAM aliases modulo DEPTH_WORDS across the low page.
   assign ram_sel = low_page;
   assign err     = 1'b0;
`endif

   // TX FIFO; a push into a full FIFO is still accepted when the head pops the same cycle.
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign push       = MemWrite && tx_sel;
   assign pop        = !fifo_empty && out_ready;
   assign push_ok    = push && (!fifo_full || pop);
   assign out_valid  = !fifo_empty;
   assign out_data   = fifo_empty ? 32'd0 : fifo_mem[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         count_q <= count_d;
         if (push && !push_ok) begin
            overflow_q <= 1'b1;
         end else if (st_wr && WriteData[2]) begin
            overflow_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q] <= WriteData;
      end
   end

   always_ff @(posedge clk) begin
      if (MemWrite && ram_sel) begin
         ram[ram_idx] <= WriteData;
      end
   end

   // A CYCLES write wins over the increment.
   assign cycles_d = cy_wr ? 32'd0 : cycles_q + 32'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycles_q <= 32'd0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   always_comb begin
      status       = 32'd0;
      status[0]    = fifo_full;
      status[1]    = fifo_empty;
      status[2]    = overflow_q;
      status[15:8] = 8'(count_q);
`ifdef DMEM_OOB_TRAP_EN
      status[3]    = err_q;
`endif
   end

   always_comb begin
      ReadData = 32'd0;
      if (ram_sel) begin
         ReadData = ram[ram_idx];
      end else if (st_sel) begin
         ReadData = status;
      end else if (cy_sel) begin
         ReadData = cycles_q;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed test-plan steps, then random traffic against a queue model.
// Honours DMEM_OOB_TRAP_EN when it is defined for the build.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned FD    = 8;
   localparam int unsigned IW    = $clog2(DEPTH);
`ifdef DMEM_OOB_TRAP_EN
   localparam bit OOB_EN = 1'b1;
`else
   localparam bit OOB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] Addr = 32'd0;
   logic [31:0] WriteData = 32'd0;
   logic        out_ready = 1'b0;
   logic [31:0] ReadData, out_data;
   logic        out_valid, err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_ram [DEPTH];
   logic [31:0] m_q [$];
   bit          m_ovf, m_err;
   logic [31:0] m_cyc;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .FIFO_DEPTH(FD)) dut (
      .clk      (clk),
      .reset    (reset),
      .MemWrite (MemWrite),
      .Addr     (Addr),
      .WriteData(WriteData),
      .ReadData (ReadData),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_oob(input logic [31:0] a);
      bit bad;
      if (a < 32'h1000) bad = (a >> 2) >= DEPTH;
      else bad = !((a >> 2) inside {32'h400, 32'h401, 32'h402});
      return OOB_EN && bad;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s       = 32'd0;
      s[15:8] = 8'(m_q.size());
      s[3]    = m_err;
      s[2]    = m_ovf;
      s[1]    = (m_q.size() == 0);
      s[0]    = (m_q.size() == FD);
      return s;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      logic [31:0] w;
      w = a >> 2;
      if (is_oob(a)) return 32'd0;
      if (a < 32'h1000) return m_ram[IW'(w % DEPTH)];
      if (w == 32'h401) return exp_status();
      if (w == 32'h402) return m_cyc;
      return 32'd0;
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_cyc = 32'd0;
   endfunction

   function automatic void model_step(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                                      input logic rdy);
      logic [31:0] w;
      bit pop, push, st_wr, oob;
      w     = a >> 2;
      pop   = (m_q.size() != 0) && rdy;
      push  = mw && (w == 32'h400);
      st_wr = mw && (w == 32'h401);
      oob   = is_oob(a);
      if (push && m_q.size() == FD && !pop) m_ovf = 1'b1;
      else if (st_wr && wd[2]) m_ovf = 1'b0;
      if (oob) m_err = 1'b1;
      else if (st_wr && wd[3]) m_err = 1'b0;
      if (mw && a < 32'h1000 && !oob) m_ram[IW'(w % DEPTH)] = wd;
      if (pop) void'(m_q.pop_front());
      if (push && m_q.size() != FD) m_q.push_back(wd);
      if (mw && w == 32'h402) m_cyc = 32'd0;
      else m_cyc = m_cyc + 32'd1;
   endfunction

   // One clock: drive at the falling edge, check just after, then advance the model.
   task automatic cycle(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic rdy);
      MemWrite = mw; Addr = a; WriteData = wd; out_ready = rdy;
      #1;
      check("rdata", ReadData, exp_read(a));
      check("valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("odata", out_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
      check("err", 32'(err), 32'(m_err));
      @(posedge clk);
      model_step(mw, a, wd, rdy);
      @(negedge clk);
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      MemWrite = 1'b0; Addr = a; WriteData = 32'd0;
      #1;
      check(tag, ReadData, exp);
      @(posedge clk);
      model_step(1'b0, a, 32'd0, out_ready);
      @(negedge clk);
   endtask

   task automatic pop_expect(input string tag, input logic [31:0] exp);
      MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0; out_ready = 1'b1;
      #1;
      check(tag, out_data, exp);
      @(posedge clk);
      model_step(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      MemWrite = 1'b0; out_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] a;
      int unsigned sel;

      model_reset();
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_odata", out_data, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      peek("rst_status", 32'h1004, 32'h0000_0002);

      for (int i = 0; i < int'(DEPTH); i++) cycle(1'b1, 32'(i * 4), 32'(i) * 32'h9E37_79B9, 1'b0);

      // RAM store then load, low address bits ignored
      cycle(1'b1, 32'h0004, 32'hDEAD_BEEF, 1'b0);
      peek("ram_4", 32'h0004, 32'hDEAD_BEEF);
      peek("ram_7", 32'h0007, 32'hDEAD_BEEF);

      // Fill, overflow, drain, clear overflow
      for (int i = 1; i <= 8; i++) cycle(1'b1, 32'h1000, 32'(i), 1'b0);
      peek("st_full", 32'h1004, 32'h0000_0801);
      cycle(1'b1, 32'h1000, 32'd9, 1'b0);
      peek("st_ovf", 32'h1004, 32'h0000_0805);
      for (int i = 1; i <= 8; i++) pop_expect("drain", 32'(i));
      check("drained_valid", 32'(out_valid), 32'd0);
      peek("st_empty_ovf", 32'h1004, 32'h0000_0006);
      cycle(1'b1, 32'h1004, 32'h4, 1'b0);
      peek("st_ovf_clr", 32'h1004, 32'h0000_0002);

      // Push and pop while full
      for (int i = 0; i < 8; i++) cycle(1'b1, 32'h1000, 32'h10 + 32'(i), 1'b0);
      cycle(1'b1, 32'h1000, 32'hAA, 1'b1);
      out_ready = 1'b0;
      peek("st_pushpop", 32'h1004, 32'h0000_0801);
      for (int i = 1; i < 8; i++) pop_expect("pp_drain", 32'h10 + 32'(i));
      pop_expect("pp_last", 32'hAA);
      check("pp_empty", 32'(out_valid), 32'd0);

      // Cycle counter
      do_reset();
      repeat (10) cycle(1'b0, 32'd0, 32'd0, 1'b0);
      peek("cyc_10", 32'h1008, 32'd10);
      cycle(1'b1, 32'h1008, 32'h1234, 1'b0);
      peek("cyc_0", 32'h1008, 32'd0);
      peek("cyc_1", 32'h1008, 32'd1);
      force dut.cycles_q = 32'hFFFF_FFFF;
      #1;
      release dut.cycles_q;
      m_cyc = 32'hFFFF_FFFF;
      peek("cyc_max", 32'h1008, 32'hFFFF_FFFF);
      peek("cyc_wrap", 32'h1008, 32'd0);

      // Asynchronous reset with words queued
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1000, 32'h31 + 32'(i), 1'b0);
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_odata", out_data, 32'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      peek("arst_status", 32'h1004, 32'h0000_0002);

`ifdef DMEM_OOB_TRAP_EN
      cycle(1'b1, 32'h0000, 32'h1234_5678, 1'b0);
      cycle(1'b0, 32'h0400, 32'd0, 1'b0);
      check("oob_err_set", 32'(err), 32'd1);
      cycle(1'b1, 32'h0400, 32'hFFFF_FFFF, 1'b0);
      peek("oob_ram0", 32'h0000, 32'h1234_5678);
      cycle(1'b1, 32'h1004, 32'h8, 1'b0);
      check("oob_err_clr", 32'(err), 32'd0);
`endif

      // Random traffic
      repeat (400) begin
         sel = $urandom_range(0, 9);
         if (sel <= 3) a = 32'($urandom_range(0, 32'hFFF));
         else if (sel <= 5) a = 32'h1000 | 32'($urandom_range(0, 3));
         else if (sel == 6) a = 32'h1004;
         else if (sel == 7) a = 32'h1008;
         else if (sel == 8) a = 32'h100C + 32'($urandom_range(0, 16) * 4);
         else a = $urandom | 32'h2000;
         cycle(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
